// File: rtl/mem_arb_pkg.sv
// ============================================================
// Module   : mem_arb_pkg
// Purpose  : Shared state/owner encodings for the memory port arbiter.
// Revision : 1.0 - initial release
// ============================================================
`default_nettype none

package mem_arb_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

  localparam logic [2:0] F3_WORD = 3'b010;

endpackage

`default_nettype wire

// File: rtl/mem_arb_pick.sv
// ============================================================
// Module   : mem_arb_pick
// Purpose  : Grant decision between fetch and data requesters.
// Revision : 1.0 - initial release
// ============================================================
`default_nettype none

module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic if_eff,
  input  logic d_eff,
  input  logic starved,
  output logic grant_valid,
  output logic grant_owner
);

  // Data wins unless a waiting fetch has already been passed over STARVE_MAX times.
  assign grant_valid = if_eff | d_eff;
  assign grant_owner = (d_eff & ~(if_eff & starved)) ? OWN_D : OWN_IF;

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================
// Module   : mem_port_arbiter
// Purpose  : Single-clock arbiter sharing one memory port between IF and MEM.
// Revision : 1.0 - initial release
// ============================================================
`default_nettype none

module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 9,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_kill,
  input  logic              halt,
  output logic              if_valid,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [2:0]        d_funct3,
  output logic              d_valid,
  output logic [31:0]       d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [2:0]        mem_funct3,
  input  logic [31:0]       mem_rdata
);

  localparam int STW = $clog2(STARVE_MAX + 1);
  localparam logic [2:0]     c_lat        = 3'(MEM_LAT);
  localparam logic [STW-1:0] c_starve_max = STW'(STARVE_MAX);

  logic [1:0]     r_state;
  logic [1:0]     w_state_next;
  logic           r_owner;
  logic           r_kill;
  logic [2:0]     r_lat_cnt;
  logic [STW-1:0] r_starve;
  logic           w_if_eff;
  logic           w_d_eff;
  logic           w_starved;
  logic           w_grant_valid;
  logic           w_grant_owner;
  logic           w_grant;
  logic           w_done;

  // A requester is masked in its own valid cycle so a held req is not re-granted.
  assign w_if_eff  = if_req & ~halt & ~if_kill & ~if_valid;
  assign w_d_eff   = d_req & ~d_valid;
  assign w_starved = (r_starve == c_starve_max);
  assign w_grant   = (r_state == IDLE) & w_grant_valid;
  assign w_done    = (r_state == WAIT) & (r_lat_cnt == c_lat);

  mem_arb_pick u_pick (
    .if_eff      (w_if_eff),
    .d_eff       (w_d_eff),
    .starved     (w_starved),
    .grant_valid (w_grant_valid),
    .grant_owner (w_grant_owner)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_grant_valid) w_state_next = ISSUE;
      ISSUE:   w_state_next = WAIT;
      WAIT:    if (w_done) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_en = 1'b0;
    if (r_state == ISSUE) mem_en = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_valid   <= 1'b0;
      d_valid    <= 1'b0;
      if_rdata   <= '0;
      d_rdata    <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_funct3 <= '0;
      r_owner    <= OWN_IF;
      r_kill     <= 1'b0;
      r_lat_cnt  <= '0;
      r_starve   <= '0;
    end else begin
      if_valid <= 1'b0;
      d_valid  <= 1'b0;

      if (w_grant) begin
        r_owner <= w_grant_owner;
        r_kill  <= 1'b0;
        if (w_grant_owner == OWN_D) begin
          mem_we     <= d_we;
          mem_addr   <= d_addr;
          mem_wdata  <= d_wdata;
          mem_funct3 <= d_funct3;
        end else begin
          mem_we     <= 1'b0;
          mem_addr   <= if_addr;
          mem_funct3 <= F3_WORD;
        end
      end

      if (r_state == ISSUE)
        r_lat_cnt <= 3'd1;
      else if ((r_state == WAIT) && !w_done)
        r_lat_cnt <= r_lat_cnt + 3'd1;

      if ((r_state != IDLE) && (r_owner == OWN_IF) && if_kill)
        r_kill <= 1'b1;

      // A kill arriving in the completion cycle itself still discards the fetch.
      if (w_done) begin
        r_kill <= 1'b0;
        if (r_owner == OWN_D) begin
          d_valid <= 1'b1;
          if (!mem_we) d_rdata <= mem_rdata;
        end else if (!(r_kill | if_kill)) begin
          if_valid <= 1'b1;
          if_rdata <= mem_rdata;
        end
      end

      if (!w_if_eff || (w_grant && (w_grant_owner == OWN_IF)))
        r_starve <= '0;
      else if (w_grant && !w_starved)
        r_starve <= r_starve + STW'(1);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Directed and random checks of mem_port_arbiter against a timestamp model.
// Revision : 1.0 - initial release
// ============================================================
`default_nettype none

module tb_mem_port_arbiter;

  localparam int ADDR_W     = 9;
  localparam int MEM_LAT    = 1;
  localparam int STARVE_MAX = 4;

  logic        clk      = 1'b0;
  logic        reset    = 1'b1;
  logic        if_req   = 1'b0;
  logic [8:0]  if_addr  = '0;
  logic        if_kill  = 1'b0;
  logic        halt     = 1'b0;
  logic        d_req    = 1'b0;
  logic        d_we     = 1'b0;
  logic [8:0]  d_addr   = '0;
  logic [31:0] d_wdata  = '0;
  logic [2:0]  d_funct3 = '0;
  logic        if_valid, d_valid, mem_en, mem_we;
  logic [31:0] if_rdata, d_rdata, mem_wdata, mem_rdata;
  logic [8:0]  mem_addr;
  logic [2:0]  mem_funct3;

  logic        pk_en = 1'b0;
  logic [8:0]  pk_a  = '0;
  logic [31:0] pk_d  = '0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill), .halt(halt),
    .if_valid(if_valid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_funct3(d_funct3),
    .d_valid(d_valid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_funct3(mem_funct3), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Memory: byte array, word read returned MEM_LAT cycles after mem_en, garbage otherwise.
  logic [7:0]  mem [512];
  logic [31:0] rpipe [MEM_LAT];
  logic [8:0]  ra;
  assign ra        = {mem_addr[8:2], 2'b00};
  assign mem_rdata = rpipe[MEM_LAT-1];

  always @(posedge clk) begin
    if (pk_en) begin
      mem[pk_a]         <= pk_d[7:0];
      mem[pk_a + 9'd1]  <= pk_d[15:8];
      mem[pk_a + 9'd2]  <= pk_d[23:16];
      mem[pk_a + 9'd3]  <= pk_d[31:24];
    end
    if (mem_en && mem_we) begin
      case (mem_funct3[1:0])
        2'd0: mem[mem_addr] <= mem_wdata[7:0];
        2'd1: begin
          mem[mem_addr]        <= mem_wdata[7:0];
          mem[mem_addr + 9'd1] <= mem_wdata[15:8];
        end
        default: begin
          mem[ra]        <= mem_wdata[7:0];
          mem[ra + 9'd1] <= mem_wdata[15:8];
          mem[ra + 9'd2] <= mem_wdata[23:16];
          mem[ra + 9'd3] <= mem_wdata[31:24];
        end
      endcase
    end
    rpipe[0] <= mem_en ? {mem[ra + 9'd3], mem[ra + 9'd2], mem[ra + 9'd1], mem[ra]} : $urandom;
    for (int i = 1; i < MEM_LAT; i++) rpipe[i] <= rpipe[i-1];
  end

  // Reference model: transactions are serialised; a grant at cycle c completes with a
  // valid pulse at c+2+MEM_LAT, and memory effects are applied in grant order.
  logic [7:0] ref_mem [512];
  bit         m_busy, m_own, m_killed, m_we;
  int         m_done_c, cyc, m_starve;
  logic [31:0] m_rd;
  bit         e_if_valid, e_d_valid, e_mem_en, e_mem_we;
  logic [8:0] e_mem_addr;
  logic [2:0] e_mem_f3;
  logic [31:0] e_mem_wdata, e_if_rdata, e_d_rdata;
  bit         eff_if, eff_d, gi, gd, n_if, n_d, n_en;

  function automatic logic [31:0] ref_word(input logic [8:0] a);
    logic [8:0] b;
    b = {a[8:2], 2'b00};
    return {ref_mem[b + 9'd3], ref_mem[b + 9'd2], ref_mem[b + 9'd1], ref_mem[b]};
  endfunction

  initial forever begin
    @(negedge clk);
    if (reset) begin
      chk("reset_if_valid", 32'(if_valid), 32'd0);
      chk("reset_d_valid",  32'(d_valid),  32'd0);
      chk("reset_mem_en",   32'(mem_en),   32'd0);
      chk("reset_mem_addr", 32'(mem_addr), 32'd0);
      chk("reset_if_rdata", if_rdata, 32'd0);
      chk("reset_d_rdata",  d_rdata,  32'd0);
      m_busy = 0; m_killed = 0; m_starve = 0; m_own = 0; m_we = 0;
      e_if_valid = 0; e_d_valid = 0; e_mem_en = 0; e_mem_we = 0;
      e_mem_addr = '0; e_mem_f3 = '0; e_mem_wdata = '0; e_if_rdata = '0; e_d_rdata = '0;
    end else begin
      chk("if_valid", 32'(if_valid), 32'(e_if_valid));
      chk("d_valid",  32'(d_valid),  32'(e_d_valid));
      chk("mem_en",   32'(mem_en),   32'(e_mem_en));
      chk("if_rdata", if_rdata, e_if_rdata);
      chk("d_rdata",  d_rdata,  e_d_rdata);
      if (e_mem_en) begin
        chk("mem_we",     32'(mem_we),     32'(e_mem_we));
        chk("mem_addr",   32'(mem_addr),   32'(e_mem_addr));
        chk("mem_funct3", 32'(mem_funct3), 32'(e_mem_f3));
        if (e_mem_we) chk("mem_wdata", mem_wdata, e_mem_wdata);
      end
      eff_if = if_req && !halt && !if_kill && !e_if_valid;
      eff_d  = d_req && !e_d_valid;
      n_if = 0; n_d = 0; n_en = 0; gi = 0; gd = 0;
      if (m_busy) begin
        if (!m_own && if_kill) m_killed = 1;
        if (cyc == m_done_c) begin
          m_busy = 0;
          if (m_own) begin
            n_d = 1;
            if (!m_we) e_d_rdata = m_rd;
          end else if (!m_killed) begin
            n_if = 1;
            e_if_rdata = m_rd;
          end
        end
      end else begin
        gi = eff_if && (!eff_d || m_starve == STARVE_MAX);
        gd = eff_d && !gi;
        if (gi || gd) begin
          m_busy = 1; m_own = gd; m_killed = 0; n_en = 1;
          m_done_c = cyc + 1 + MEM_LAT;
          if (gi) begin
            m_we = 0; e_mem_we = 0; e_mem_addr = if_addr; e_mem_f3 = 3'b010;
            m_rd = ref_word(if_addr);
          end else begin
            m_we = d_we; e_mem_we = d_we; e_mem_addr = d_addr; e_mem_f3 = d_funct3;
            e_mem_wdata = d_wdata;
            if (d_we) begin
              case (d_funct3[1:0])
                2'd0: ref_mem[d_addr] = d_wdata[7:0];
                2'd1: {ref_mem[d_addr + 9'd1], ref_mem[d_addr]} = d_wdata[15:0];
                default: {ref_mem[d_addr + 9'd3], ref_mem[d_addr + 9'd2],
                          ref_mem[d_addr + 9'd1], ref_mem[d_addr]} = d_wdata;
              endcase
            end else begin
              m_rd = ref_word(d_addr);
            end
          end
        end
      end
      if (gi || !eff_if) m_starve = 0;
      else if (gd && m_starve < STARVE_MAX) m_starve++;
      e_if_valid = n_if; e_d_valid = n_d; e_mem_en = n_en;
    end
    if (pk_en) {ref_mem[pk_a + 9'd3], ref_mem[pk_a + 9'd2], ref_mem[pk_a + 9'd1], ref_mem[pk_a]} = pk_d;
    cyc++;
  end

  task automatic cyc_start();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc_start();
  endtask

  task automatic new_data(input bit we);
    int sz;
    sz = $urandom_range(2);
    d_req = 1'b1;
    d_we  = we;
    case (sz)
      0:       d_addr = 9'($urandom_range(511));
      1:       d_addr = 9'($urandom_range(255) << 1);
      default: d_addr = 9'($urandom_range(127) << 2);
    endcase
    d_funct3 = 3'(sz);
    if (!we && sz < 2 && $urandom_range(1) == 1) d_funct3[2] = 1'b1;
    d_wdata = $urandom;
  endtask

  bit got;
  int n_dv;

  initial begin
    for (int i = 0; i < 128; i++) begin
      cyc_start(); pk_en = 1'b1; pk_a = 9'(i * 4); pk_d = $urandom;
    end
    cyc_start(); pk_en = 1'b1; pk_a = 9'h010; pk_d = 32'h00500093;
    cyc_start(); pk_a = 9'h104; pk_d = 32'hDEADBEEF;
    cyc_start(); pk_a = 9'h020; pk_d = 32'h00A00113;
    cyc_start(); pk_en = 1'b0;
    chk("reset_state_idle", 32'({if_valid, d_valid, mem_en, mem_we}), 32'd0);
    reset = 1'b0;
    idle(2);

    // Fetch alone
    cyc_start(); if_req = 1'b1; if_addr = 9'h010;
    cyc_start(); chk("fa_mem_en", 32'(mem_en), 32'd1); chk("fa_funct3", 32'(mem_funct3), 32'd2);
    cyc_start(); chk("fa_not_early", 32'(if_valid), 32'd0);
    cyc_start(); chk("fa_if_valid", 32'(if_valid), 32'd1); chk("fa_if_rdata", if_rdata, 32'h00500093);
    if_req = 1'b0;
    idle(2);

    // Simultaneous requests: data first, fetch granted in the d_valid cycle
    cyc_start(); if_req = 1'b1; if_addr = 9'h020;
    d_req = 1'b1; d_we = 1'b0; d_addr = 9'h104; d_funct3 = 3'b010; d_wdata = '0;
    cyc_start(); chk("sim_data_first", 32'(mem_addr), 32'h104);
    idle(1);
    cyc_start(); chk("sim_d_valid", 32'(d_valid), 32'd1); chk("sim_d_rdata", d_rdata, 32'hDEADBEEF);
    chk("sim_no_if_valid", 32'(if_valid), 32'd0);
    d_req = 1'b0;
    cyc_start(); chk("sim_fetch_issue", 32'(mem_addr), 32'h020);
    idle(1);
    cyc_start(); chk("sim_if_valid", 32'(if_valid), 32'd1); chk("sim_if_rdata", if_rdata, 32'h00A00113);
    if_req = 1'b0;
    idle(2);

    // Kill of an in-flight fetch
    cyc_start(); if_req = 1'b1; if_addr = 9'h030;
    cyc_start(); chk("kill_mem_en", 32'(mem_en), 32'd1);
    cyc_start(); if_kill = 1'b1; if_req = 1'b0;
    cyc_start(); chk("kill_no_valid", 32'(if_valid), 32'd0); chk("kill_rdata_kept", if_rdata, 32'h00A00113);
    if_kill = 1'b0; if_req = 1'b1; if_addr = 9'h010;
    idle(2);
    cyc_start(); chk("kill_next_valid", 32'(if_valid), 32'd1); chk("kill_next_rdata", if_rdata, 32'h00500093);
    if_req = 1'b0;
    idle(2);

    // Starvation guard: held stores with a pending fetch
    cyc_start(); if_req = 1'b1; if_addr = 9'h040; new_data(1'b1);
    got = 0; n_dv = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      cyc_start();
      if (d_valid) begin n_dv++; new_data(1'b1); end
      if (if_valid) begin got = 1; if_req = 1'b0; end
    end
    chk("starve_fetch_served", 32'(got), 32'd1);
    chk("starve_data_bound", 32'(n_dv <= STARVE_MAX), 32'd1);
    got = 0;
    for (int k = 0; k < 10 && !got; k++) begin
      cyc_start();
      if (d_valid) begin got = 1; d_req = 1'b0; end
    end
    chk("starve_drain", 32'(got), 32'd1);
    idle(2);

    // Halt blocks new fetches only
    cyc_start(); halt = 1'b1; if_req = 1'b1; if_addr = 9'h050;
    for (int k = 0; k < 10; k++) begin
      cyc_start(); chk("halt_no_mem_en", 32'(mem_en), 32'd0);
    end
    new_data(1'b1);
    got = 0;
    for (int k = 0; k < 10 && !got; k++) begin
      cyc_start();
      if (d_valid) begin got = 1; d_req = 1'b0; end
    end
    chk("halt_store_served", 32'(got), 32'd1);
    halt = 1'b0;
    got = 0;
    for (int k = 0; k < 10 && !got; k++) begin
      cyc_start();
      if (if_valid) begin got = 1; if_req = 1'b0; end
    end
    chk("halt_release_fetch", 32'(got), 32'd1);
    idle(2);

    // Reset during WAIT abandons the transaction
    cyc_start(); d_req = 1'b1; d_we = 1'b0; d_addr = 9'h104; d_funct3 = 3'b010;
    idle(2);
    reset = 1'b1;
    #1;
    chk("rst_wait_ctrl", 32'({mem_en, if_valid, d_valid, mem_we}), 32'd0);
    chk("rst_wait_addr", 32'(mem_addr), 32'd0);
    chk("rst_wait_d_rdata", d_rdata, 32'd0);
    idle(2);
    reset = 1'b0; d_req = 1'b0;
    got = 0;
    for (int k = 0; k < 6; k++) begin
      cyc_start();
      if (d_valid || if_valid) got = 1;
    end
    chk("rst_no_valid", 32'(got), 32'd0);

    // Random traffic against the model
    for (int k = 0; k < 3000; k++) begin
      cyc_start();
      if (if_req && e_if_valid) begin
        if_req  = ($urandom_range(3) != 0);
        if_addr = 9'($urandom_range(127) << 2);
      end else if (!if_req && $urandom_range(2) == 0) begin
        if_req  = 1'b1;
        if_addr = 9'($urandom_range(127) << 2);
      end
      if_kill = ($urandom_range(15) == 0);
      if (if_kill) if_addr = 9'($urandom_range(127) << 2);
      if ($urandom_range(31) == 0) halt = ~halt;
      if (d_req && e_d_valid) begin
        if ($urandom_range(1) == 1) new_data(1'($urandom_range(1)));
        else d_req = 1'b0;
      end else if (!d_req && $urandom_range(3) == 0) begin
        new_data(1'($urandom_range(1)));
      end
    end
    cyc_start(); if_req = 1'b0; d_req = 1'b0; if_kill = 1'b0; halt = 1'b0;
    idle(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
